button_speed_select: RTL and testbench
======================================

Name: button_speed_select

Overview:
- Front end that generates the speed-select button vector consumed by the LED cycler.
- Synchronises and debounces the five raw Basys3 pushbuttons.
- On each debounced press, latches a held one-hot speed selection plus a binary code and a change strobe.
- Sits between the top-level button pins and `led_cycle.buttons`; `speed_sel` connects directly to that input.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its stable value before the stable value updates. Use 16 for simulation and 500000 on the board. Must be ≥ 2; a smaller value is an elaboration error.
- CNT_W, 20, width of each per-button debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  5  raw pushbuttons, asynchronous, active-high; bit0 = slowest … bit4 = fastest
- stable_btn  output  5  debounced button levels
- speed_sel  output  5  registered one-hot selected speed; drives `led_cycle.buttons`
- speed_code  output  3  binary index of the set bit in speed_sel (0..4)
- sel_changed  output  1  one-cycle pulse when speed_sel takes a new value

Behaviour:
- Reset (asynchronous assert, synchronous release) sets:
  - both synchroniser stages to 0
  - all counters to 0
  - stable_btn = 0, and the internal stable_d = 0
  - speed_sel = 5'b00001, speed_code = 0, sel_changed = 0
- Synchroniser: two flops per bit. sync2 is the sampled value.
- Debounce, per bit, independent of the other bits:
  - If sync2 == stable: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable ← sync2 and counter ← 0.
  - Else: counter ← counter + 1.
- Debounce timing:
  - A clean raw transition sampled at edge k appears on stable_btn at edge k + DEBOUNCE_CYCLES + 1. Latency counted from the first sampling edge is DEBOUNCE_CYCLES + 2 edges.
  - Any glitch or bounce that returns to the stable level before the count completes resets the counter, so no output change occurs.
- Press detect: rise = stable_btn & ~stable_d; stable_d is stable_btn delayed by one cycle.
  - Releases (falling edges) are ignored.
  - The selection is held indefinitely after release.
- Selection register, updated on the edge after rise is nonzero:
  - idx = highest set bit of rise. Simultaneous presses resolve to the faster speed.
  - If onehot(idx) != speed_sel: speed_sel ← onehot(idx), speed_code ← idx, sel_changed ← 1 for exactly one cycle.
  - If onehot(idx) == speed_sel (re-pressing the current speed): no register change and no strobe.
  - sel_changed is 0 on every other cycle.
- Press-to-output latency: a raw press reaches speed_sel DEBOUNCE_CYCLES + 3 edges after first sampling.
- Invariants:
  - speed_sel is always exactly one-hot and never 0.
  - speed_code always equals the index of the set bit in speed_sel.
- Held buttons: a button held continuously produces one rise only.
  - Pressing a second button while the first is held still generates a rise for the second and selects it.
- Button held through reset: after rst_n releases, the button debounces like a new press and selects its speed at DEBOUNCE_CYCLES + 3 edges.
- Reset asserted mid-debounce or mid-press: all state clears immediately (asynchronous). No strobe is emitted during or on exit from reset.
- Counters never wrap: the maximum value reached is DEBOUNCE_CYCLES-1.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, all btn_raw=0 → speed_sel=00001, speed_code=0, stable_btn=0, sel_changed=0 throughout 20 cycles.
- btn_raw=00100 held clean from edge k → stable_btn[2]=1 at edge k+5; speed_sel=00100, speed_code=2, single-cycle sel_changed at edge k+6; after release speed_sel stays 00100.
- btn_raw[3] bounces 1,0,1,1,0 (each ≤3 cycles), then holds 1 → no change until 4 consecutive sync2=1 cycles; then exactly one sel_changed and speed_sel=01000.
- btn_raw=10001 rising in the same cycle → speed_sel=10000, speed_code=4, exactly one strobe; re-press of bit4 later → no strobe, speed_sel unchanged.
- Hold bit1, then press bit3 while bit1 is still held → speed_sel goes 00010, then 01000, with two strobes in total; releasing both leaves 01000.
- Pull rst_n low 2 cycles into a bit4 debounce → speed_sel=00001 immediately and no strobe. If btn_raw[4] stays high, speed_sel=10000 at 7 edges after rst_n deasserts.

Source files
------------

// File: rtl/button_speed_select.sv
// Synchronises, debounces and press-detects five pushbuttons into a held one-hot speed select.
// Latency: raw press to speed_sel is DEBOUNCE_CYCLES+3 edges; free-running, no backpressure.
module button_speed_select #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] stable_btn,
    output logic [4:0] speed_sel,
    output logic [2:0] speed_code,
    output logic       sel_changed
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("button_speed_select: DEBOUNCE_CYCLES must be >= 2");
        end
        if ((longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
            $error("button_speed_select: CNT_W too narrow for DEBOUNCE_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       stable_d;
    logic [CNT_W-1:0] cnt [5];
    logic [4:0]       rise;
    logic [2:0]       idx;
    logic [4:0]       new_sel;

    // Counter only runs while the synchronised level disagrees with the stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            stable_btn <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == stable_btn[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable_btn[i] <= sync2[i];
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_btn & ~stable_d;

    // Highest rising bit wins so simultaneous presses pick the faster speed.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (rise[i]) idx = 3'(i);
        end
    end

    assign new_sel = 5'b00001 << idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d    <= '0;
            speed_sel   <= 5'b00001;
            speed_code  <= 3'd0;
            sel_changed <= 1'b0;
        end else begin
            stable_d    <= stable_btn;
            sel_changed <= 1'b0;
            if ((rise != 5'b0) && (new_sel != speed_sel)) begin
                speed_sel   <= new_sel;
                speed_code  <= idx;
                sel_changed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_speed_select.sv
// Self-checking bench for button_speed_select: directed scenarios plus random button activity
// compared every cycle against a behavioural model of debounce and press selection.
module tb_button_speed_select;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = 5'b0;
    logic [4:0] stable_btn;
    logic [4:0] speed_sel;
    logic [2:0] speed_code;
    logic       sel_changed;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    button_speed_select #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .stable_btn  (stable_btn),
        .speed_sel   (speed_sel),
        .speed_code  (speed_code),
        .sel_changed (sel_changed)
    );

    always #5 clk = ~clk;

    // Model state: raw samples two edges back, per-bit disagreement run length, selection.
    logic [4:0] m_s1 = 5'b0, m_s2 = 5'b0, m_stable = 5'b0, m_prev = 5'b0, m_sel = 5'b00001;
    logic [2:0] m_code = 3'd0;
    logic       m_chg = 1'b0;
    int         run [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [4:0] pressed;
        int hi;
        for (int b = 0; b < 5; b++) run[b] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 5'b0; m_s2 = 5'b0; m_stable = 5'b0; m_prev = 5'b0;
                m_sel = 5'b00001; m_code = 3'd0; m_chg = 1'b0;
                for (int b = 0; b < 5; b++) run[b] = 0;
            end else begin
                pressed = m_stable & ~m_prev;
                m_chg = 1'b0;
                hi = -1;
                for (int b = 0; b < 5; b++) if (pressed[b]) hi = b;
                if (hi >= 0 && m_sel != (5'b00001 << hi)) begin
                    m_sel  = 5'b00001 << hi;
                    m_code = 3'(hi);
                    m_chg  = 1'b1;
                end
                m_prev = m_stable;
                for (int b = 0; b < 5; b++) begin
                    if (m_s2[b] == m_stable[b]) run[b] = 0;
                    else begin
                        run[b]++;
                        if (run[b] == D) begin
                            m_stable[b] = m_s2[b];
                            run[b] = 0;
                        end
                    end
                end
                m_s2 = m_s1;
                m_s1 = btn_raw;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_compare", int'({stable_btn, speed_sel, speed_code, sel_changed}),
                int'({m_stable, m_sel, m_code, m_chg}));
            chk("onehot_code", int'(speed_sel), int'(5'b00001 << speed_code));
            if (sel_changed) strobes++;
        end
    end

    task automatic cyc(input logic [4:0] b);
        btn_raw = b;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(5'b0);
    endtask

    int s0;
    logic [4:0] rb;

    initial begin
        rst_n = 1'b0;
        btn_raw = 5'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        idle(20);
        chk("reset_sel", int'(speed_sel), 1);
        chk("reset_strobes", strobes, 0);

        // Clean press of bit2.
        s0 = strobes;
        for (int n = 1; n <= 8; n++) begin
            cyc(5'b00100);
            if (n == 5) chk("clean_stable_early", int'(stable_btn), 0);
            if (n == 6) begin
                chk("clean_stable", int'(stable_btn), 5'b00100);
                chk("clean_sel_early", int'(speed_sel), 5'b00001);
            end
            if (n == 7) begin
                chk("clean_sel", int'(speed_sel), 5'b00100);
                chk("clean_code", int'(speed_code), 2);
                chk("clean_strobe", int'(sel_changed), 1);
            end
            if (n == 8) chk("clean_strobe_off", int'(sel_changed), 0);
        end
        idle(10);
        chk("clean_held_sel", int'(speed_sel), 5'b00100);
        chk("clean_strobes", strobes - s0, 1);

        // Bouncing bit3: highest run of ones is 3 cycles, then a steady hold.
        s0 = strobes;
        begin
            logic [9:0] bounce;
            bounce = 10'b1100111000;
            for (int i = 9; i >= 0; i--) cyc(bounce[i] ? 5'b01000 : 5'b0);
        end
        chk("bounce_no_change", int'(speed_sel), 5'b00100);
        chk("bounce_stable", int'(stable_btn), 0);
        for (int i = 0; i < 12; i++) cyc(5'b01000);
        chk("bounce_sel", int'(speed_sel), 5'b01000);
        chk("bounce_strobes", strobes - s0, 1);
        idle(10);

        // Simultaneous bits 0 and 4, then re-press of bit4.
        s0 = strobes;
        for (int i = 0; i < 10; i++) cyc(5'b10001);
        chk("simul_sel", int'(speed_sel), 5'b10000);
        chk("simul_code", int'(speed_code), 4);
        idle(10);
        for (int i = 0; i < 10; i++) cyc(5'b10000);
        idle(3);
        chk("repress_sel", int'(speed_sel), 5'b10000);
        chk("simul_repress_strobes", strobes - s0, 1);

        // Bit1 held, bit3 pressed on top of it.
        s0 = strobes;
        for (int i = 0; i < 10; i++) cyc(5'b00010);
        chk("hold_first_sel", int'(speed_sel), 5'b00010);
        for (int i = 0; i < 10; i++) cyc(5'b01010);
        idle(10);
        chk("hold_second_sel", int'(speed_sel), 5'b01000);
        chk("hold_strobes", strobes - s0, 2);

        // Reset two cycles into a bit4 debounce with the button kept high.
        s0 = strobes;
        cyc(5'b10000);
        cyc(5'b10000);
        rst_n = 1'b0;
        #1;
        chk("rst_async_sel", int'(speed_sel), 1);
        chk("rst_async_strobe", int'(sel_changed), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            cyc(5'b10000);
            if (n == 6) chk("rst_rel_sel_early", int'(speed_sel), 1);
            if (n == 7) chk("rst_rel_sel", int'(speed_sel), 5'b10000);
        end
        idle(5);
        chk("rst_strobes", strobes - s0, 1);

        // Random button activity with occasional resets.
        rb = 5'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 6) rb[$urandom_range(0, 4)] ^= 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                cyc(rb);
                rst_n = 1'b1;
            end
            cyc(rb);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
